dmem_bridge: RTL and testbench

Data-memory bridge directly downstream of the datapath's memory stage. It turns the single-cycle M-stage access (`memwriteM`, `sig_write`, `aluoutM`, `writedataM`) into a variable-latency request/response transaction on the SRAM-like data bus. It returns `readdataM` and stalls the pipeline until the access completes. It holds returned read data while other stall sources keep the M stage frozen.

---
 rtl/mips_mem_pkg.sv | 18 +
 rtl/dmem_bridge_wstrb_decode.sv | 63 ++++++
 rtl/dmem_bridge.sv | 112 +++++++++++
 tb/tb_dmem_bridge.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory bridge: FSM state encoding and
// bus transfer size codes.
package mips_mem_pkg;

  // Bridge FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  // Bus transfer size codes (data_size)
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage : mips_mem_pkg

// File: rtl/dmem_bridge_wstrb_decode.sv
// Byte-strobe decoder: classifies the M-stage write strobe pattern into
// legality, direction, transfer size and the low address bits (lane).
module wstrb_decode
  import mips_mem_pkg::*;
(
  input  logic [3:0] wen,
  output logic       legal,
  output logic       is_write,
  output logic [1:0] size,
  output logic [1:0] lane
);

  // One flag per single-byte strobe pattern (0001, 0010, 0100, 1000)
  logic [3:0] byte_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_hit
      assign byte_hit[gi] = (wen == (4'b0001 << gi));
    end
  endgenerate

  // Map the strobe pattern to request attributes; unlisted patterns are illegal
  always_comb begin
    legal    = 1'b0;
    is_write = 1'b0;
    size     = SZ_WORD;
    lane     = 2'b00;
    case (wen)
      4'b0000: begin
        legal = 1'b1;
      end
      4'b0011: begin
        legal    = 1'b1;
        is_write = 1'b1;
        size     = SZ_HALF;
        lane     = 2'b00;
      end
      4'b1100: begin
        legal    = 1'b1;
        is_write = 1'b1;
        size     = SZ_HALF;
        lane     = 2'b10;
      end
      4'b1111: begin
        legal    = 1'b1;
        is_write = 1'b1;
        size     = SZ_WORD;
        lane     = 2'b00;
      end
      default: begin
        if (|byte_hit) begin
          legal    = 1'b1;
          is_write = 1'b1;
          size     = SZ_BYTE;
          // Encode the one-hot byte strobe as a 2-bit lane index
          lane     = {byte_hit[3] | byte_hit[2], byte_hit[3] | byte_hit[1]};
        end
      end
    endcase
  end

endmodule : wstrb_decode

// File: rtl/dmem_bridge.sv
// Data-memory bridge: converts the single-cycle M-stage access into a
// request/response transaction on the SRAM-like bus, stalling the pipeline
// until the response arrives and holding read data while M stays frozen.
module dmem_bridge
  import mips_mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_en,
  input  logic [3:0]    mem_wen,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  input  logic          longest_stall,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_stall,
  output logic          data_req,
  output logic          data_wr,
  output logic [1:0]    data_size,
  output logic [AW-1:0] data_addr,
  output logic [DW-1:0] data_wdata,
  input  logic          data_addr_ok,
  input  logic [DW-1:0] data_rdata,
  input  logic          data_data_ok
);

  state_e        state_q, state_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic       acc_legal;
  logic       acc_write;
  logic [1:0] acc_size;
  logic [1:0] acc_lane;

  wstrb_decode u_wstrb_decode (
    .wen      (mem_wen),
    .legal    (acc_legal),
    .is_write (acc_write),
    .size     (acc_size),
    .lane     (acc_lane)
  );

  // Request fields come straight from the M stage, which mem_stall keeps frozen.
  // Reads are always word-sized; lane selection happens downstream in W.
  always_comb begin
    data_wr    = acc_write;
    data_size  = acc_write ? acc_size : SZ_WORD;
    data_addr  = {mem_addr[AW-1:2], (acc_write ? acc_lane : 2'b00)};
    data_wdata = mem_wdata;
  end

  // Next-state, handshake and stall logic for the single outstanding transaction
  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    data_req  = 1'b0;
    mem_stall = 1'b0;
    mem_rdata = rdata_q;
    // Outputs are forced quiet while reset is asserted
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (mem_en && acc_legal) begin
            data_req  = 1'b1;
            mem_stall = 1'b1;
            state_d   = data_addr_ok ? WAIT : REQ;
          end
        end
        REQ: begin
          data_req  = 1'b1;
          mem_stall = 1'b1;
          if (data_addr_ok) begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (data_data_ok) begin
            // Response releases the stall in the same cycle
            mem_rdata = data_rdata;
            rdata_d   = data_rdata;
            state_d   = longest_stall ? DONE : IDLE;
          end else begin
            mem_stall = 1'b1;
          end
        end
        DONE: begin
          // Hold the result without re-issuing while another source freezes M
          if (!longest_stall) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and captured read data; reset abandons any in-flight transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

endmodule : dmem_bridge

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: walks loads, stores, illegal strobes, held
// results, reset mid-transaction and back-to-back accesses.
module tb_dmem_bridge;

  logic        clk;
  logic        rst;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        longest_stall;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic [31:0] data_rdata;
  logic        data_data_ok;

  int n_vec;
  int n_err;

  dmem_bridge #(.AW(32), .DW(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_en        (mem_en),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .longest_stall (longest_stall),
    .mem_rdata     (mem_rdata),
    .mem_stall     (mem_stall),
    .data_req      (data_req),
    .data_wr       (data_wr),
    .data_size     (data_size),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_addr_ok  (data_addr_ok),
    .data_rdata    (data_rdata),
    .data_data_ok  (data_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("vec %0d %s observed %h expected %h", n_vec, tag, obs, exp);
  endtask

  // Advance to just after the next rising edge; inputs are then driven
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    mem_en = 1'b0; mem_wen = 4'b0000; mem_addr = '0; mem_wdata = '0;
    longest_stall = 1'b0; data_addr_ok = 1'b0; data_rdata = '0; data_data_ok = 1'b0;

    // Reset state
    tick(); settle();
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_stall", {31'b0, mem_stall}, 32'h0);
    chk("rst_req", {31'b0, data_req}, 32'h0);
    rst = 1'b0;

    // Word load, fast slave: addr_ok in cycle 0, data_ok in cycle 1
    tick();
    mem_en = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h1000_0006; data_addr_ok = 1'b1;
    settle();
    chk("ld_req_c0", {31'b0, data_req}, 32'h1);
    chk("ld_addr", data_addr, 32'h1000_0004);
    chk("ld_size", {30'b0, data_size}, 32'd2);
    chk("ld_wr", {31'b0, data_wr}, 32'h0);
    chk("ld_stall_c0", {31'b0, mem_stall}, 32'h1);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    settle();
    chk("ld_stall_c1", {31'b0, mem_stall}, 32'h0);
    chk("ld_req_c1", {31'b0, data_req}, 32'h0);
    chk("ld_rdata_c1", mem_rdata, 32'hDEAD_BEEF);
    tick();
    mem_en = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    settle();
    chk("ld_rdata_held", mem_rdata, 32'hDEAD_BEEF);
    chk("ld_idle_stall", {31'b0, mem_stall}, 32'h0);

    // Byte store, slow accept: addr_ok delayed 3 cycles
    tick();
    mem_en = 1'b1; mem_wen = 4'b0100; mem_addr = 32'h20; mem_wdata = 32'h00AB_0000;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("sb_req_wait", {31'b0, data_req}, 32'h1);
      chk("sb_stall_wait", {31'b0, mem_stall}, 32'h1);
      tick();
    end
    data_addr_ok = 1'b1;
    settle();
    chk("sb_req_acc", {31'b0, data_req}, 32'h1);
    chk("sb_addr", data_addr, 32'h22);
    chk("sb_size", {30'b0, data_size}, 32'd0);
    chk("sb_wr", {31'b0, data_wr}, 32'h1);
    chk("sb_wdata", data_wdata, 32'h00AB_0000);
    tick();
    data_addr_ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("sb_wait_req", {31'b0, data_req}, 32'h0);
      chk("sb_wait_stall", {31'b0, mem_stall}, 32'h1);
      tick();
    end
    data_data_ok = 1'b1; data_rdata = 32'h0000_0055;
    settle();
    chk("sb_done_stall", {31'b0, mem_stall}, 32'h0);
    chk("sb_done_rdata", mem_rdata, 32'h0000_0055);
    tick();
    data_data_ok = 1'b0;

    // Half store upper lane, fast slave
    mem_wen = 4'b1100; mem_addr = 32'h40; mem_wdata = 32'h1234_0000; data_addr_ok = 1'b1;
    settle();
    chk("sh_addr", data_addr, 32'h42);
    chk("sh_size", {30'b0, data_size}, 32'd1);
    chk("sh_req", {31'b0, data_req}, 32'h1);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0;
    settle();
    chk("sh_done_stall", {31'b0, mem_stall}, 32'h0);
    tick();
    data_data_ok = 1'b0;

    // Half store lower lane and word store: address/size decode only
    mem_wen = 4'b0011; mem_addr = 32'h46; data_addr_ok = 1'b1;
    settle();
    chk("sh_lo_addr", data_addr, 32'h44);
    chk("sh_lo_size", {30'b0, data_size}, 32'd1);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1;
    tick();
    data_data_ok = 1'b0;
    mem_wen = 4'b1111; mem_addr = 32'h4B; data_addr_ok = 1'b1;
    settle();
    chk("sw_addr", data_addr, 32'h48);
    chk("sw_size", {30'b0, data_size}, 32'd2);
    chk("sw_wr", {31'b0, data_wr}, 32'h1);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1;
    tick();
    data_data_ok = 1'b0;

    // Byte store on lane 3
    mem_wen = 4'b1000; mem_addr = 32'h50; data_addr_ok = 1'b1;
    settle();
    chk("sb3_addr", data_addr, 32'h53);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1;
    tick();
    data_data_ok = 1'b0;

    // Illegal strobe 0110: dropped, no request, no stall
    mem_wen = 4'b0110; mem_addr = 32'h60; data_addr_ok = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("ill_req", {31'b0, data_req}, 32'h0);
      chk("ill_stall", {31'b0, mem_stall}, 32'h0);
      tick();
    end
    data_addr_ok = 1'b0;

    // Held result: load completes while longest_stall is high for 3 cycles
    mem_wen = 4'b0000; mem_addr = 32'h80; data_addr_ok = 1'b1;
    settle();
    chk("hold_req", {31'b0, data_req}, 32'h1);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678; longest_stall = 1'b1;
    settle();
    chk("hold_c1_stall", {31'b0, mem_stall}, 32'h0);
    chk("hold_c1_rdata", mem_rdata, 32'h1234_5678);
    tick();
    data_data_ok = 1'b0; data_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("hold_done_req", {31'b0, data_req}, 32'h0);
      chk("hold_done_stall", {31'b0, mem_stall}, 32'h0);
      chk("hold_done_rdata", mem_rdata, 32'h1234_5678);
      tick();
    end
    longest_stall = 1'b0;
    settle();
    chk("hold_fall_req", {31'b0, data_req}, 32'h0);
    chk("hold_fall_rdata", mem_rdata, 32'h1234_5678);
    tick();
    // Back in IDLE: the still-present access is issued as a new request
    data_addr_ok = 1'b1;
    settle();
    chk("hold_idle_req", {31'b0, data_req}, 32'h1);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0000_0001;
    settle();
    chk("hold_reissue_rdata", mem_rdata, 32'h0000_0001);
    tick();
    data_data_ok = 1'b0;

    // Reset in WAIT: pending response is discarded
    mem_addr = 32'h90; data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    settle();
    chk("rw_wait_stall", {31'b0, mem_stall}, 32'h1);
    rst = 1'b1;
    settle();
    chk("rw_rst_stall", {31'b0, mem_stall}, 32'h0);
    chk("rw_rst_req", {31'b0, data_req}, 32'h0);
    chk("rw_rst_rdata", mem_rdata, 32'h0);
    tick();
    mem_en = 1'b0;
    rst = 1'b0;
    tick();
    data_data_ok = 1'b1; data_rdata = 32'hAAAA_AAAA;
    settle();
    chk("rw_resp_stall", {31'b0, mem_stall}, 32'h0);
    chk("rw_resp_rdata", mem_rdata, 32'h0);
    tick();
    data_data_ok = 1'b0;
    settle();
    chk("rw_after_rdata", mem_rdata, 32'h0);

    // Back-to-back: load then word store on consecutive M instructions
    tick();
    mem_en = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h100; data_addr_ok = 1'b1;
    settle();
    chk("b2b_ld_req", {31'b0, data_req}, 32'h1);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0000_0011;
    settle();
    chk("b2b_ld_cmp_req", {31'b0, data_req}, 32'h0);
    chk("b2b_ld_rdata", mem_rdata, 32'h0000_0011);
    tick();
    data_data_ok = 1'b0; mem_wen = 4'b1111; mem_addr = 32'h104; mem_wdata = 32'hCAFE_F00D;
    settle();
    chk("b2b_st_req", {31'b0, data_req}, 32'h1);
    chk("b2b_st_wr", {31'b0, data_wr}, 32'h1);
    chk("b2b_st_addr", data_addr, 32'h104);
    tick();
    data_addr_ok = 1'b1;
    settle();
    chk("b2b_st_req_hold", {31'b0, data_req}, 32'h1);
    tick();
    data_addr_ok = 1'b0;
    settle();
    chk("b2b_st_wait_req", {31'b0, data_req}, 32'h0);
    tick();
    data_data_ok = 1'b1; data_rdata = 32'h0000_0022;
    settle();
    chk("b2b_st_done_stall", {31'b0, mem_stall}, 32'h0);
    chk("b2b_st_rdata", mem_rdata, 32'h0000_0022);
    tick();
    mem_en = 1'b0; data_data_ok = 1'b0;
    settle();
    chk("b2b_final_req", {31'b0, data_req}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_dmem_bridge
